// File: rtl/ws2812_pixel_serializer.sv
// WS2812B pixel serializer: takes BITS-wide pixel words over valid/ready and drives the
// NZR data line MSB first, inserting the latch low period whenever the stream runs dry.
module ws2812_pixel_serializer #(
  parameter int BITS = 24,
  parameter int T0H  = 40,
  parameter int T1H  = 80,
  parameter int TBIT = 125,
  parameter int TRST = 6000
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic [BITS-1:0] pix_data_i,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  output logic            dout_o,
  output logic            busy_o,
  output logic            frame_done_o
);

  localparam int CW = $clog2(TBIT);
  localparam int LW = $clog2(TRST + 1);
  localparam int IW = $clog2(BITS);

  localparam logic [CW-1:0] T0H_C     = CW'(T0H);
  localparam logic [CW-1:0] T1H_C     = CW'(T1H);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
  localparam logic [LW-1:0] TRST_LAST = LW'(TRST - 1);
  localparam logic [IW-1:0] BIT_TOP   = IW'(BITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] hold_q, hold_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            hold_full_q, hold_full_d;
  logic            dout_q, dout_d;
  logic [IW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            take;
  logic            load;
  logic            bypass;

  assign pix_ready_o = !hold_full_q;
  assign take        = pix_valid_i && !hold_full_q;
  assign dout_o      = dout_q;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    cyc_d        = cyc_q;
    lat_d        = lat_q;
    load         = 1'b0;
    bypass       = 1'b0;
    frame_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cyc_q == TBIT_LAST) begin
          cyc_d = '0;
          if (bit_q != '0) begin
            bit_d   = bit_q - 1'b1;
            shift_d = {shift_q[BITS-2:0], 1'b0};
          end else if (hold_full_q) begin
            load = 1'b1;
          end else if (take) begin
            // A word arriving on the pixel-end edge goes straight to the shifter.
            load   = 1'b1;
            bypass = 1'b1;
          end else begin
            state_d = LATCH;
            lat_d   = '0;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      LATCH: begin
        if (lat_q == TRST_LAST) begin
          frame_done_o = 1'b1;
          state_d      = IDLE;
          lat_d        = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shift_d = bypass ? pix_data_i : hold_q;
      bit_d   = BIT_TOP;
      cyc_d   = '0;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load && !bypass) begin
      hold_full_d = 1'b0;
    end
    if (take && !bypass) begin
      hold_d      = pix_data_i;
      hold_full_d = 1'b1;
    end
  end

  // dout is registered, so it is computed from the counter value of the coming cycle.
  always_comb begin
    dout_d = (state_d == SEND) && (cyc_d < (shift_d[BITS-1] ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      cyc_q       <= '0;
      lat_q       <= '0;
      dout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cyc_q       <= cyc_d;
      lat_q       <= lat_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: doc/ws2812_pixel_serializer.md
Name: ws2812_pixel_serializer

Overview:
- Parametrised successor to the single-bit WS2812B generator: accepts whole pixel words (GRB 24-bit or GRBW 32-bit) over a valid/ready handshake.
- Serialises each word MSB first with NZR bit timing and inserts the latch (RET) low period automatically when the stream runs dry.
- Sits between the frame/pixel sequencer and the LED data pin on the BASYS 3 (100 MHz clk).

Parameters:
- BITS, 24, bits per pixel (24 = GRB, 32 = GRBW); legal values 8..32.
- T0H, 40, clk cycles dout is high for a '0' bit (400 ns @ 100 MHz).
- T1H, 80, clk cycles dout is high for a '1' bit (800 ns).
- TBIT, 125, total clk cycles per bit (1.25 us); requires 0 < T0H < T1H < TBIT.
- TRST, 6000, clk cycles of low latch time after the last bit of a frame (60 us).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- pix_data  input  BITS  pixel word, bit BITS-1 sent first.
- pix_valid  input  1  pix_data is valid.
- pix_ready  output  1  serializer can take a word; transfer on a rising clk edge with pix_valid && pix_ready.
- dout  output  1  registered WS2812B data line.
- busy  output  1  high in SEND or LATCH.
- frame_done  output  1  one-cycle pulse on the last cycle of LATCH.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; dout=0, busy=0, frame_done=0, hold register empty, pix_ready=1 once reset is released; all counters 0.
- Storage: one-entry hold register plus a BITS-wide shift register. pix_ready = !hold_full, independent of state, so the next word can be accepted while the current one shifts.
- States:
  - IDLE: dout=0. If the hold register is full, load the shifter from it, clear hold, bit index = BITS-1, cycle counter = 0, go to SEND.
  - SEND: cycle counter runs 0..TBIT-1. dout=1 while counter < (current bit ? T1H : T0H), else 0. At counter = TBIT-1, either step to the next bit or, after bit 0, go to the pixel-end decision.
  - Pixel end (taken at counter=TBIT-1 of bit 0): if the hold register is full at that edge, including a word accepted on that same edge, reload the shifter and start the next pixel's bit BITS-1 on the next cycle with no gap. Otherwise go to LATCH.
  - LATCH: dout=0 for exactly TRST cycles. frame_done=1 on the final cycle, then go to IDLE. Words may be accepted into hold during LATCH, but transmission waits until LATCH completes.
- Latency: a handshake at edge E while in IDLE with hold empty loads hold at E. The shifter loads and dout goes high at E+1 (the first SEND cycle is one cycle after the transfer edge).
- Simultaneous events:
  - Handshake and hold-to-shifter move on the same edge: the held word moves and the new word is captured. Legal only when hold was empty, because pix_ready gates the transfer.
  - pix_valid with pix_ready=0: the word is not taken. The upstream block holds pix_data and pix_valid stable until it is taken.
- Gaps between pixels inside a frame are not supported. Any underrun produces a full latch, which the LEDs see as end of frame. This is intentional.
- Reset asserted mid-bit or mid-latch: dout drops to 0 immediately and the hold contents are discarded. After release, a new frame starts directly from IDLE. The sequencer must issue its own latch if it needs the LED chain cleared.
- Width rules:
  - Cycle counter width: $clog2(TBIT).
  - Latch counter width: $clog2(TRST+1).
  - Bit index width: $clog2(BITS).
- Counters never wrap outside their defined ranges.

Test Plan (sim params T0H=4, T1H=8, TBIT=12, TRST=60, BITS=24, 10 ns clk):
- Reset: hold reset low 3 cycles, then release -> dout=0, busy=0, frame_done=0, pix_ready=1. Assert reset asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
- Single pixel: send 24'hA50000 as one handshake -> dout first rises 1 cycle after the transfer. Per-bit high widths are 8,4,8,4,4,8,4,8 cycles, then sixteen bits of 4, each bit 12 cycles long. Then 60 low cycles, frame_done pulses on cycle 60, state returns to IDLE.
- Back-to-back: pix_valid held high with words 24'hFFFFFF and 24'h000000 -> 48 contiguous bit periods, no extra cycles between pixels. pix_ready drops after the second word is taken and rises when it moves into the shifter.
- Backpressure: keep pix_valid high with hold full -> pix_ready=0 and pix_data is not sampled until the current pixel finishes. A word presented during LATCH is sent only after frame_done.
- Reset mid-operation: pulse reset low during bit 5 of a pixel -> dout=0 immediately, busy=0. The word left in hold is not transmitted after release.
- GRBW build (BITS=32): send 32'h8000_0001 -> first bit high 8 cycles, bit 0 high 8 cycles, 30 middle bits high 4 cycles each, then latch.
